// File: rtl/alu.sv
// alu: registered 32-bit integer ALU for the execute stage.
// One of 16 operations per cycle, one-cycle latency, registered negative/zero flags.
// Optional feature macro: ALU_MULDIV_EN. When it is defined, opcodes 12-15
// (MUL/DIVU/REMU/MULHU) are implemented. When it is undefined, those opcodes
// register zero.
module alu (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input1,
    input  logic [31:0] input2,
    input  logic [3:0]  alu_operation,
    output logic [31:0] out,
    output logic        negative,
    output logic        zero
);

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned SHAMT_W = 5;

    typedef enum logic [3:0] {
        OP_PASS  = 4'd0,
        OP_ADD   = 4'd1,
        OP_SUB   = 4'd2,
        OP_AND   = 4'd3,
        OP_OR    = 4'd4,
        OP_SLL   = 4'd5,
        OP_SRL   = 4'd6,
        OP_XOR   = 4'd7,
        OP_SLT   = 4'd8,
        OP_SLTU  = 4'd9,
        OP_NOR   = 4'd10,
        OP_SRA   = 4'd11,
        OP_MUL   = 4'd12,
        OP_DIVU  = 4'd13,
        OP_REMU  = 4'd14,
        OP_MULHU = 4'd15
    } alu_op_e;

    logic [DATA_W-1:0]  r_out;
    logic               r_negative;
    logic               r_zero;

    logic [DATA_W-1:0]  w_result;
    logic [SHAMT_W-1:0] w_shamt;
    alu_op_e            w_op;
    logic               w_slt;
    logic               w_sltu;

    // Only the low five bits of operand B select the shift distance.
    assign w_shamt = input2[SHAMT_W-1:0];
    assign w_op    = alu_op_e'(alu_operation);
    assign w_slt   = ($signed(input1) < $signed(input2));
    assign w_sltu  = (input1 < input2);

`ifdef ALU_MULDIV_EN
    logic [2*DATA_W-1:0] w_prod;
    logic [DATA_W-1:0]   w_quot;
    logic [DATA_W-1:0]   w_rem;
    logic                w_div_by_zero;

    // Single-cycle combinational multiply and divide.
    // Divide by zero returns all ones for the quotient and the dividend for the remainder.
    assign w_prod        = (2*DATA_W)'(input1) * (2*DATA_W)'(input2);
    assign w_div_by_zero = (input2 == '0);
    assign w_quot        = w_div_by_zero ? '1 : (input1 / input2);
    assign w_rem         = w_div_by_zero ? input1 : (input1 % input2);
`endif

    // Select the result of the current opcode.
    always_comb begin
        w_result = '0;
        case (w_op)
            OP_PASS:  w_result = input1;
            OP_ADD:   w_result = input1 + input2;
            OP_SUB:   w_result = input1 - input2;
            OP_AND:   w_result = input1 & input2;
            OP_OR:    w_result = input1 | input2;
            OP_SLL:   w_result = input1 << w_shamt;
            OP_SRL:   w_result = input1 >> w_shamt;
            OP_XOR:   w_result = input1 ^ input2;
            OP_SLT:   w_result = DATA_W'(w_slt);
            OP_SLTU:  w_result = DATA_W'(w_sltu);
            OP_NOR:   w_result = ~(input1 | input2);
            OP_SRA:   w_result = DATA_W'($signed(input1) >>> w_shamt);
`ifdef ALU_MULDIV_EN
            OP_MUL:   w_result = w_prod[DATA_W-1:0];
            OP_DIVU:  w_result = w_quot;
            OP_REMU:  w_result = w_rem;
            OP_MULHU: w_result = w_prod[2*DATA_W-1:DATA_W];
`else
            OP_MUL:   w_result = '0;
            OP_DIVU:  w_result = '0;
            OP_REMU:  w_result = '0;
            OP_MULHU: w_result = '0;
`endif
            default:  w_result = '0;
        endcase
    end

    // Register the result and flags. Reset takes priority over the operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out      <= '0;
            r_negative <= 1'b0;
            r_zero     <= 1'b1;
        end else begin
            r_out      <= w_result;
            r_negative <= w_result[DATA_W-1];
            r_zero     <= (w_result == '0);
        end
    end

    assign out      = r_out;
    assign negative = r_negative;
    assign zero     = r_zero;

endmodule

// File: tb/tb_alu.sv
// tb_alu: directed and randomized checks of alu against an arithmetic reference model.
module tb_alu;

    logic        clk;
    logic        rst;
    logic [31:0] input1;
    logic [31:0] input2;
    logic [3:0]  alu_operation;
    logic [31:0] out;
    logic        negative;
    logic        zero;

    int n_checks;
    int n_pass;

    alu dut (
        .clk          (clk),
        .rst          (rst),
        .input1       (input1),
        .input2       (input2),
        .alu_operation(alu_operation),
        .out          (out),
        .negative     (negative),
        .zero         (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef ALU_MULDIV_EN
    localparam bit MULDIV = 1'b1;
`else
    localparam bit MULDIV = 1'b0;
`endif

    // Reference result computed with 64-bit integer arithmetic.
    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint unsigned ua;
        longint unsigned ub;
        longint          sa;
        longint          sb;
        int              s;
        longint unsigned r;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        s  = int'(b % 32);
        r  = 64'd0;
        case (op)
            4'd0:  r = ua;
            4'd1:  r = ua + ub;
            4'd2:  r = ua - ub;
            4'd3:  r = ua & ub;
            4'd4:  r = ua | ub;
            4'd5:  r = ua * (64'd1 << s);
            4'd6:  r = ua / (64'd1 << s);
            4'd7:  r = ua ^ ub;
            4'd8:  r = (sa < sb) ? 64'd1 : 64'd0;
            4'd9:  r = (ua < ub) ? 64'd1 : 64'd0;
            4'd10: r = ~(ua | ub);
            4'd11: r = 64'(sa >>> s);
            4'd12: r = MULDIV ? ua * ub : 64'd0;
            4'd13: r = MULDIV ? ((ub == 0) ? 64'hFFFF_FFFF : ua / ub) : 64'd0;
            4'd14: r = MULDIV ? ((ub == 0) ? ua : ua % ub) : 64'd0;
            4'd15: r = MULDIV ? ((ua * ub) >> 32) : 64'd0;
            default: r = 64'd0;
        endcase
        return r[31:0];
    endfunction

    // Compare result and both flags against an expected result value.
    task automatic check(input string tag, input logic [31:0] exp);
        logic exp_neg;
        logic exp_zero;
        exp_neg  = exp[31];
        exp_zero = (exp == 32'd0);
        n_checks++;
        assert (out === exp) n_pass++;
        else $error("FAIL %s out: got %h expected %h", tag, out, exp);
        n_checks++;
        assert (negative === exp_neg) n_pass++;
        else $error("FAIL %s negative: got %b expected %b", tag, negative, exp_neg);
        n_checks++;
        assert (zero === exp_zero) n_pass++;
        else $error("FAIL %s zero: got %b expected %b", tag, zero, exp_zero);
    endtask

    // Present one operation, let it register, then sample after the edge.
    task automatic apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        rst           = 1'b0;
        alu_operation = op;
        input1        = a;
        input2        = b;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
        apply(op, a, b);
        check(tag, exp);
    endtask

    logic [3:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        rst           = 1'b1;
        alu_operation = 4'd1;
        input1        = 32'h1234_5678;
        input2        = 32'h0000_0001;

        // Reset held for two cycles with arbitrary inputs.
        repeat (2) @(posedge clk);
        #1;
        check("reset", 32'd0);

        // First op after reset release.
        run("rel_add", 4'd1, 32'd15, 32'd42, 32'd57);
        run("sub",  4'd2,  32'd15, 32'd42, 32'hFFFF_FFE5);
        run("and",  4'd3,  32'd15, 32'd42, 32'd10);
        run("or",   4'd4,  32'd15, 32'd42, 32'd47);
        run("xor",  4'd7,  32'd15, 32'd42, 32'd37);
        run("nor",  4'd10, 32'd15, 32'd42, 32'hFFFF_FFD0);
        run("pass", 4'd0,  32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF);
        run("add_wrap", 4'd1, 32'hFFFF_FFFF, 32'd1, 32'd0);

        run("sll",  4'd5,  32'd15, 32'd4, 32'd240);
        run("srl",  4'd6,  32'd255, 32'd4, 32'd15);
        run("sra",  4'd11, 32'h8000_0000, 32'd4, 32'hF800_0000);
        run("sll_mask", 4'd5, 32'd1, 32'd36, 32'd16);

        run("slt_pos_neg",  4'd8, 32'd7, -32'sd3, 32'd0);
        run("sltu_pos_neg", 4'd9, 32'd7, -32'sd3, 32'd1);
        run("sltu_lt",      4'd9, 32'd7, 32'd8, 32'd1);
        run("slt_neg_zero", 4'd8, -32'sd1, 32'd0, 32'd1);

        if (MULDIV) begin
            run("mul",     4'd12, 32'd32, 32'd8, 32'd256);
            run("divu",    4'd13, 32'd32, 32'd8, 32'd4);
            run("remu",    4'd14, 32'd32, 32'd8, 32'd0);
            run("mulhu",   4'd15, 32'd32, 32'd8, 32'd0);
            run("divu_z",  4'd13, 32'd32, 32'd0, 32'hFFFF_FFFF);
            run("remu_z",  4'd14, 32'd32, 32'd0, 32'd32);
            run("mulhu_big", 4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        end else begin
            run("mul_off",  4'd12, 32'd32, 32'd8, 32'd0);
            run("divu_off", 4'd13, 32'd32, 32'd0, 32'd0);
            run("add_on",   4'd1,  32'd32, 32'd8, 32'd40);
        end

        // Outputs hold with stable inputs.
        run("hold0", 4'd2, 32'd1, 32'd3, 32'hFFFF_FFFE);
        @(posedge clk);
        #1;
        check("hold1", 32'hFFFF_FFFE);

        // Reset wins over a nonzero operation in the same cycle.
        @(negedge clk);
        rst           = 1'b1;
        alu_operation = 4'd1;
        input1        = 32'd5;
        input2        = 32'd6;
        @(posedge clk);
        #1;
        check("rst_prio", 32'd0);
        run("post_rst", 4'd1, 32'd5, 32'd6, 32'd11);

        // Randomized operations against the model.
        for (int i = 0; i < 400; i++) begin
            r_op = 4'($urandom_range(0, 15));
            r_a  = $urandom;
            r_b  = $urandom;
            case ($urandom_range(0, 4))
                0: r_b = 32'($urandom_range(0, 40));
                1: r_b = 32'd0;
                2: r_a = r_b;
                default: ;
            endcase
            run("rand", r_op, r_a, r_b, model(r_op, r_a, r_b));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu.md
# alu

Registered 32-bit integer arithmetic/logic unit for the processor datapath's execute stage. Each cycle it applies one of 16 operations, selected by a 4-bit opcode, to two 32-bit operands. It registers the result together with negative and zero status flags, which feed branch resolution and writeback.

## Interface
- Parameters: none; all widths are fixed.
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset; synchronous and active-high.
- input1  input  32  operand A.
- input2  input  32  operand B.
- alu_operation  input  4  opcode; encodings are listed under Operation.
- out  output  32  registered result.
- negative  output  1  registered; equals out[31].
- zero  output  1  registered; 1 when out == 0.

## Operation
Opcode encodings (A = input1, B = input2, shamt = B[4:0]):
- 0 PASS: A.
- 1 ADD: A+B, modulo 2^32.
- 2 SUB: A−B, modulo 2^32.
- 3 AND: A&B.
- 4 OR: A|B.
- 5 SLL: A << shamt.
- 6 SRL: A >> shamt, logical.
- 7 XOR: A^B.
- 8 SLT: 1 if signed(A) < signed(B), else 0.
- 9 SLTU: 1 if unsigned(A) < unsigned(B), else 0.
- 10 NOR: ~(A|B).
- 11 SRA: A >>> shamt, arithmetic (sign-filled).
- 12 MUL: low 32 bits of A*B.
- 13 DIVU: unsigned A/B.
- 14 REMU: unsigned A%B.
- 15 MULHU: high 32 bits of the unsigned 64-bit product A*B.

Rules:
- No carry or overflow outputs. Overflow wraps silently.
- Shifts use only B[4:0]. B[31:5] is ignored.
- Divide by zero: DIVU returns 0xFFFFFFFF; REMU returns A.
- Flags are always derived from the value being registered into out, for every opcode including comparisons.
  - negative = result[31].
  - zero = (result == 0).

## Timing
- The result is computed combinationally from the operands and opcode present before the rising edge, and registered at that edge. Latency is 1 cycle.
- Throughput is one operation per cycle. There is no handshake and no stall.
- Reset values, applied at the next edge while rst=1: out=0, negative=0, zero=1.
- rst has priority over any operation presented in the same cycle.
- Deasserting rst: the first result is the operation presented in the first cycle with rst=0. It appears after the following edge.
- Outputs hold their last values while the inputs are stable. They re-register every cycle; no enable is provided.
- Changing the opcode or operands mid-stream is always legal. Only the values sampled at each edge matter.

## Configuration
- Macro ALU_MULDIV_EN.
- Defined: opcodes 12–15 behave as specified above. The multiply and divide logic is combinational and single-cycle.
- Undefined: the multiplier and divider are not synthesized. Opcodes 12–15 register out=0, negative=0, zero=1. All other opcodes are unaffected.

## Test plan
- Reset: hold rst=1 for 2 cycles with arbitrary inputs -> out=0, negative=0, zero=1. Release rst with op1, A=15, B=42 -> out=57 one cycle later.
- Add/sub/logic with A=15, B=42:
  - op2 -> 0xFFFFFFE5, negative=1.
  - op3 -> 10.
  - op4 -> 47.
  - op7 -> 37.
  - op10 -> 0xFFFFFFD0.
  - Each result appears exactly one cycle after it is applied.
- Shifts:
  - op5 with A=15, B=4 -> 240.
  - op6 with A=255, B=4 -> 15.
  - op11 with A=0x80000000, B=4 -> 0xF8000000, negative=1.
  - op5 with A=1, B=36 -> 16 (only B[4:0] is used).
- Compares:
  - op8 with A=7, B=−3 -> 0, zero=1.
  - op9 with A=7, B=−3 -> 1.
  - op9 with A=7, B=8 -> 1.
  - op8 with A=−1, B=0 -> 1.
- Mul/div with ALU_MULDIV_EN defined, A=32, B=8:
  - op12 -> 256.
  - op13 -> 4.
  - op14 -> 0, zero=1.
  - op15 -> 0.
  - op13 with B=0 -> 0xFFFFFFFF.
  - op14 with B=0 -> 32.
- Build without ALU_MULDIV_EN: op12 with A=32, B=8 -> out=0, zero=1. op1 with the same operands still -> 40.
